// File: rtl/tagfile_pkg.sv
// Shared types, constants and index helpers for the tagfile retire arbiter.
package tagfile_pkg;

  localparam int TF_ADDR_W = 5;
  localparam int TF_DATA_W = 32;
  localparam int unsigned ZERO_REG = 0;

  typedef struct packed {
    logic [TF_ADDR_W-1:0] addr;
    logic [TF_DATA_W-1:0] data;
  } retire_req_t;

  // Single-step modular wrap; callers never exceed 2*n-1.
  function automatic int wrap_idx(input int i, input int n);
    return (i >= n) ? (i - n) : i;
  endfunction

endpackage

// File: rtl/tagfile_retire_arbiter_rr_multi_select.sv
// Round-robin multi-grant selector: walks requesters from ptr, grants up to PORTS
// non-zero-address requests (zero-address ones ride along), skipping address conflicts.
module rr_multi_select
  import tagfile_pkg::*;
#(
  parameter int REQS   = 4,
  parameter int PORTS  = 2,
  parameter int ADDR_W = 5,
  parameter int PTR_W  = $clog2(REQS),
  parameter int PIDX_W = (PORTS > 1) ? $clog2(PORTS) : 1
) (
  input  logic [REQS-1:0]        valid,
  input  logic [REQS*ADDR_W-1:0] addr,
  input  logic [PTR_W-1:0]       ptr,
  output logic [REQS-1:0]        grant,
  output logic [REQS-1:0]        grant_nz,
  output logic [REQS*PIDX_W-1:0] grant_port,
  output logic [PTR_W-1:0]       new_ptr
);

  logic [ADDR_W-1:0] addr_s [REQS];

  always_comb begin
    for (int i = 0; i < REQS; i++) begin
      addr_s[i] = addr[i*ADDR_W +: ADDR_W];
    end
  end

  always_comb begin
    int   idx;
    int   cnt;
    logic hit;
    logic nz;
    grant      = {REQS{1'b0}};
    grant_nz   = {REQS{1'b0}};
    grant_port = {(REQS*PIDX_W){1'b0}};
    new_ptr    = ptr;
    cnt        = 0;
    for (int k = 0; k < REQS; k++) begin
      idx = wrap_idx(int'(ptr) + k, REQS);
      nz  = (addr_s[idx] != ADDR_W'(ZERO_REG));
      hit = 1'b0;
      // Only already-granted non-zero writes block a later same-address request.
      for (int j = 0; j < REQS; j++) begin
        hit = hit | (grant_nz[j] & (addr_s[j] == addr_s[idx]));
      end
      if (valid[idx] && (cnt < PORTS) && !hit) begin
        grant[idx]    = 1'b1;
        grant_nz[idx] = nz;
        grant_port[idx*PIDX_W +: PIDX_W] = PIDX_W'(cnt);
        new_ptr       = PTR_W'(wrap_idx(idx + 1, REQS));
        cnt           = cnt + (nz ? 1 : 0);
      end else begin
        grant[idx] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/tagfile_retire_arbiter.sv
// Tagfile retire arbiter top: fairness pointer, registered write ports, flush/reset masking.
module tagfile_retire_arbiter
  import tagfile_pkg::*;
#(
  parameter int REQS   = 4,
  parameter int PORTS  = 2,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [REQS-1:0]          req_valid,
  input  logic [REQS*ADDR_W-1:0]   req_addr,
  input  logic [REQS*DATA_W-1:0]   req_data,
  output logic [REQS-1:0]          req_ready,
  input  logic                     flush,
  output logic [PORTS-1:0]         wr_en,
  output logic [PORTS*ADDR_W-1:0]  wr_addr,
  output logic [PORTS*DATA_W-1:0]  wr_data,
  output logic                     busy
);

  localparam int PTR_W  = $clog2(REQS);
  localparam int PIDX_W = (PORTS > 1) ? $clog2(PORTS) : 1;

  logic [PTR_W-1:0]         rr_ptr_q, rr_ptr_d;
  logic [PORTS-1:0]         wr_en_q, wr_en_d;
  logic [PORTS*ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [PORTS*DATA_W-1:0]  wr_data_q, wr_data_d;
  logic                     busy_q, busy_d;

  logic [REQS-1:0]          grant_s;
  logic [REQS-1:0]          grant_nz_s;
  logic [REQS*PIDX_W-1:0]   grant_port_s;
  logic [PTR_W-1:0]         new_ptr_s;
  logic                     sel_s;

  rr_multi_select #(
    .REQS   (REQS),
    .PORTS  (PORTS),
    .ADDR_W (ADDR_W),
    .PTR_W  (PTR_W),
    .PIDX_W (PIDX_W)
  ) u_sel (
    .valid      (req_valid),
    .addr       (req_addr),
    .ptr        (rr_ptr_q),
    .grant      (grant_s),
    .grant_nz   (grant_nz_s),
    .grant_port (grant_port_s),
    .new_ptr    (new_ptr_s)
  );

  // Grants are withheld during flush and while reset is held.
  always_comb begin
    req_ready = (flush || !rst_n) ? {REQS{1'b0}} : grant_s;
  end

  always_comb begin
    wr_en_d   = {PORTS{1'b0}};
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    rr_ptr_d  = rr_ptr_q;
    sel_s     = 1'b0;
    if (flush) begin
      rr_ptr_d = {PTR_W{1'b0}};
    end else begin
      rr_ptr_d = new_ptr_s;
      for (int p = 0; p < PORTS; p++) begin
        for (int i = 0; i < REQS; i++) begin
          sel_s = grant_nz_s[i] && (grant_port_s[i*PIDX_W +: PIDX_W] == PIDX_W'(p));
          if (sel_s) begin
            wr_en_d[p]                   = 1'b1;
            wr_addr_d[p*ADDR_W +: ADDR_W] = req_addr[i*ADDR_W +: ADDR_W];
            wr_data_d[p*DATA_W +: DATA_W] = req_data[i*DATA_W +: DATA_W];
          end else begin
            wr_en_d[p] = wr_en_d[p];
          end
        end
      end
    end
    busy_d = |wr_en_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q  <= {PTR_W{1'b0}};
      wr_en_q   <= {PORTS{1'b0}};
      wr_addr_q <= {(PORTS*ADDR_W){1'b0}};
      wr_data_q <= {(PORTS*DATA_W){1'b0}};
      busy_q    <= 1'b0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_tagfile_retire_arbiter.sv
// Directed bench for the 2-port arbiter plus a randomised fairness/scoreboard run on a 1-port copy.
module tb_tagfile_retire_arbiter;

  localparam int REQS = 4;
  localparam int AW   = 5;
  localparam int DW   = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [REQS-1:0]    a_valid, a_ready, b_valid, b_ready;
  logic [REQS*AW-1:0] a_addr, b_addr;
  logic [REQS*DW-1:0] a_data, b_data;
  logic               a_flush, b_flush, a_busy, b_busy;
  logic [1:0]         a_wr_en;
  logic [2*AW-1:0]    a_wr_addr;
  logic [2*DW-1:0]    a_wr_data;
  logic [0:0]         b_wr_en;
  logic [AW-1:0]      b_wr_addr;
  logic [DW-1:0]      b_wr_data;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  tagfile_retire_arbiter #(.REQS(REQS), .PORTS(2), .ADDR_W(AW), .DATA_W(DW)) dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(a_valid), .req_addr(a_addr), .req_data(a_data),
    .req_ready(a_ready), .flush(a_flush), .wr_en(a_wr_en), .wr_addr(a_wr_addr),
    .wr_data(a_wr_data), .busy(a_busy)
  );

  tagfile_retire_arbiter #(.REQS(REQS), .PORTS(1), .ADDR_W(AW), .DATA_W(DW)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(b_valid), .req_addr(b_addr), .req_data(b_data),
    .req_ready(b_ready), .flush(b_flush), .wr_en(b_wr_en), .wr_addr(b_wr_addr),
    .wr_data(b_wr_data), .busy(b_busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [AW-1:0] ad, input logic [DW-1:0] d);
    a_valid[i]          = v;
    a_addr[i*AW +: AW]  = ad;
    a_data[i*DW +: DW]  = d;
  endtask

  task automatic all_four();
    for (int i = 0; i < REQS; i++) begin
      set_req(i, 1'b1, AW'(i + 1), 32'h1000_0000 | (i + 1));
    end
  endtask

  int              wait_c [REQS];
  int              nz_cnt;
  logic [REQS-1:0] rdy;
  logic            exp_v;
  logic [AW-1:0]   exp_a;
  logic [DW-1:0]   exp_d;

  initial begin
    a_valid = '0; a_addr = '0; a_data = '0; a_flush = 1'b0;
    b_valid = '0; b_addr = '0; b_data = '0; b_flush = 1'b0;
    for (int i = 0; i < REQS; i++) wait_c[i] = 0;
    repeat (2) step();

    // Reset values, with requests already pending
    all_four();
    #1;
    chk("rst_ready", 64'(a_ready), 64'h0);
    chk("rst_wr_en", 64'(a_wr_en), 64'h0);
    chk("rst_busy", 64'(a_busy), 64'h0);
    chk("rst_wr_addr", 64'(a_wr_addr), 64'h0);
    chk("rst_wr_data", a_wr_data, 64'h0);
    rst_n = 1'b1;
    #1;

    // All four valid, two ports
    chk("rr_ready0", 64'(a_ready), 64'(4'b0011));
    step();
    chk("rr_wr_en0", 64'(a_wr_en), 64'(2'b11));
    chk("rr_wr_addr0", 64'(a_wr_addr), 64'({5'd2, 5'd1}));
    chk("rr_wr_data0", a_wr_data, {32'h1000_0002, 32'h1000_0001});
    chk("rr_busy0", 64'(a_busy), 64'h1);
    set_req(0, 1'b0, 5'd0, 32'h0);
    set_req(1, 1'b0, 5'd0, 32'h0);
    #1;
    chk("rr_ready1", 64'(a_ready), 64'(4'b1100));
    step();
    chk("rr_wr_en1", 64'(a_wr_en), 64'(2'b11));
    chk("rr_wr_addr1", 64'(a_wr_addr), 64'({5'd4, 5'd3}));

    // Async reset while both ports are active
    all_four();
    rst_n = 1'b0;
    #1;
    chk("arst_wr_en", 64'(a_wr_en), 64'h0);
    chk("arst_busy", 64'(a_busy), 64'h0);
    chk("arst_ready", 64'(a_ready), 64'h0);
    chk("arst_wr_addr", 64'(a_wr_addr), 64'h0);
    step();
    rst_n = 1'b1;
    #1;
    chk("arst_first_grant", 64'(a_ready), 64'(4'b0011));
    chk("arst_ptr", 64'(dut_a.rr_ptr_q), 64'h0);
    step();
    chk("arst_wr_addr2", 64'(a_wr_addr), 64'({5'd2, 5'd1}));
    a_valid = '0;
    step();
    chk("idle_wr_en", 64'(a_wr_en), 64'h0);
    chk("idle_hold_addr", 64'(a_wr_addr), 64'({5'd2, 5'd1}));
    chk("idle_busy", 64'(a_busy), 64'h0);
    chk("idle_ptr", 64'(dut_a.rr_ptr_q), 64'h2);

    // Flush dominates grants and resets the pointer
    set_req(0, 1'b1, 5'd1, 32'h1000_0001);
    set_req(1, 1'b1, 5'd2, 32'h1000_0002);
    set_req(2, 1'b1, 5'd3, 32'h1000_0003);
    a_flush = 1'b1;
    #1;
    chk("flush_ready", 64'(a_ready), 64'h0);
    step();
    chk("flush_wr_en", 64'(a_wr_en), 64'h0);
    chk("flush_ptr", 64'(dut_a.rr_ptr_q), 64'h0);
    a_flush = 1'b0;
    #1;
    chk("post_flush_ready", 64'(a_ready), 64'(4'b0011));
    step();
    chk("post_flush_wr_addr", 64'(a_wr_addr), 64'({5'd2, 5'd1}));
    set_req(0, 1'b0, 5'd0, 32'h0);
    set_req(1, 1'b0, 5'd0, 32'h0);
    #1;
    chk("post_flush_ready2", 64'(a_ready), 64'(4'b0100));
    step();
    chk("single_port_wr_en", 64'(a_wr_en), 64'(2'b01));
    chk("single_port_addr", 64'(a_wr_addr[AW-1:0]), 64'h3);
    chk("single_port_ptr", 64'(dut_a.rr_ptr_q), 64'h3);
    a_valid = '0;
    a_flush = 1'b1;
    step();
    a_flush = 1'b0;

    // Same-address conflict
    set_req(0, 1'b1, 5'd7, 32'hAAAA_0007);
    set_req(1, 1'b1, 5'd7, 32'hBBBB_0007);
    set_req(2, 1'b1, 5'd9, 32'hCCCC_0009);
    #1;
    chk("conf_ready0", 64'(a_ready), 64'(4'b0101));
    step();
    chk("conf_wr_en0", 64'(a_wr_en), 64'(2'b11));
    chk("conf_wr_addr0", 64'(a_wr_addr), 64'({5'd9, 5'd7}));
    chk("conf_wr_data0", a_wr_data, {32'hCCCC_0009, 32'hAAAA_0007});
    chk("conf_ptr", 64'(dut_a.rr_ptr_q), 64'h3);
    set_req(0, 1'b0, 5'd0, 32'h0);
    set_req(2, 1'b0, 5'd0, 32'h0);
    #1;
    chk("conf_ready1", 64'(a_ready), 64'(4'b0010));
    step();
    chk("conf_wr_en1", 64'(a_wr_en), 64'(2'b01));
    chk("conf_wr_addr1", 64'(a_wr_addr[AW-1:0]), 64'h7);
    chk("conf_wr_data1", 64'(a_wr_data[DW-1:0]), 64'hBBBB_0007);
    a_valid = '0;
    a_flush = 1'b1;
    step();
    a_flush = 1'b0;

    // Zero register request rides along without a port
    set_req(0, 1'b1, 5'd0, 32'h0000_00AA);
    set_req(1, 1'b1, 5'd3, 32'h3333_0003);
    set_req(2, 1'b1, 5'd5, 32'h5555_0005);
    #1;
    chk("zero_ready", 64'(a_ready), 64'(4'b0111));
    step();
    chk("zero_wr_en", 64'(a_wr_en), 64'(2'b11));
    chk("zero_wr_addr", 64'(a_wr_addr), 64'({5'd5, 5'd3}));
    chk("zero_wr_data", a_wr_data, {32'h5555_0005, 32'h3333_0003});
    chk("zero_ptr", 64'(dut_a.rr_ptr_q), 64'h3);
    a_valid = '0;
    step();
    chk("zero_idle", 64'(a_wr_en), 64'h0);

    // Random traffic on the single-port instance: fairness and exactly-once delivery
    for (int c = 0; c < 1500; c++) begin
      #1;
      rdy    = b_ready;
      exp_v  = 1'b0;
      exp_a  = '0;
      exp_d  = '0;
      nz_cnt = 0;
      for (int i = 0; i < REQS; i++) begin
        if (b_valid[i] && rdy[i]) begin
          chk("fair_wait", 64'(wait_c[i] <= REQS), 64'h1);
          wait_c[i] = 0;
          if (b_addr[i*AW +: AW] != 5'd0) begin
            nz_cnt++;
            exp_v = 1'b1;
            exp_a = b_addr[i*AW +: AW];
            exp_d = b_data[i*DW +: DW];
          end
        end else if (b_valid[i]) begin
          wait_c[i]++;
        end
      end
      chk("one_write_per_cycle", 64'(nz_cnt <= 1), 64'h1);
      step();
      chk("rand_wr_en", 64'(b_wr_en), 64'(exp_v));
      if (exp_v) begin
        chk("rand_wr_addr", 64'(b_wr_addr), 64'(exp_a));
        chk("rand_wr_data", 64'(b_wr_data), 64'(exp_d));
      end
      for (int i = 0; i < REQS; i++) begin
        if (!b_valid[i] || rdy[i]) begin
          b_valid[i]         = ($urandom_range(0, 2) != 0);
          b_addr[i*AW +: AW] = AW'($urandom_range(0, 3));
          b_data[i*DW +: DW] = $urandom;
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
